mul_digit_sequencer: RTL



---
 rtl/mul_digit_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mul_digit_sequencer.sv
// mul_digit_sequencer
// -------------------
// Sequential WIDTH x WIDTH unsigned multiplier. Both operands are split into
// 2-bit digits, and every digit pair (i, j) is multiplied in turn by a 2x2
// cell. Each partial product is shifted by 2*(i+j) and added into a
// 2*WIDTH-bit accumulator. Pairs with i+j < APPROX_WEIGHT take their product
// from an approximate 2x2 cell (3*3 -> 7). All other pairs use the exact cell.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   IN_VALID   operand pair valid
//   IN_READY   block can accept operands (high in IDLE)
//   A, B       unsigned operands, sampled only on the accept edge
//   OUT_VALID  result valid (high in DONE)
//   OUT_READY  consumer accepts the result
//   OUT_P      2*WIDTH-bit product, held until the next result is loaded
//   BUSY       high while digit pairs are being accumulated (RUN)

// 2x2 multiplier cell. With APPROX=1 the single case 3*3 gives 7 instead of 9.
// Every other product is exact, so the approximate cell never exceeds the
// exact one.
module Multiplier_2x2 #(
    parameter bit APPROX = 1'b0
) (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    always_comb begin
        p = {2'b00, a} * {2'b00, b};
        if (APPROX && (a == 2'd3) && (b == 2'd3)) begin
            p = 4'd7;
        end
    end
endmodule

module mul_digit_sequencer #(
    parameter int WIDTH         = 8,
    parameter int APPROX_WEIGHT = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   OUT_P,
    output logic                 BUSY
);
    localparam int N    = WIDTH / 2;
    localparam int NN   = N * N;
    localparam int IDXW = $clog2(NN);
    localparam int PW   = 2 * WIDTH;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     out_p_q, out_p_d;

    logic [1:0]        a_dig;
    logic [1:0]        b_dig;
    logic [3:0]        p_exact;
    logic [3:0]        p_approx;
    logic [3:0]        p_sel;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_sum;
    int                dig_i;
    int                dig_j;

    // Both cells see the current digit pair. The mux below chooses per pair.
    Multiplier_2x2 #(.APPROX(1'b0)) u_exact (
        .a (a_dig),
        .b (b_dig),
        .p (p_exact)
    );

    Multiplier_2x2 #(.APPROX(1'b1)) u_approx (
        .a (a_dig),
        .b (b_dig),
        .p (p_approx)
    );

    // idx walks the A digits fastest (i = idx mod N) and then the B digits
    // (j = idx / N). The partial product weight is 4^(i+j).
    always_comb begin
        dig_i   = int'(idx_q) % N;
        dig_j   = int'(idx_q) / N;
        a_dig   = a_q[2*dig_i +: 2];
        b_dig   = b_q[2*dig_j +: 2];
        p_sel   = ((dig_i + dig_j) < APPROX_WEIGHT) ? p_approx : p_exact;
        pp      = {{(PW-4){1'b0}}, p_sel} << (2 * (dig_i + dig_j));
        acc_sum = acc_q + pp;
    end

    // Next-state and datapath control. OUT_P is loaded with the final sum on
    // the same edge that adds the last pair, so DONE starts with a ready result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    out_p_d = acc_sum;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Moving to IDLE here means new operands wait one more cycle.
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A synchronous reset abandons any multiplication in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_p_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q == RUN);
    assign OUT_VALID = (state_q == DONE);
    assign OUT_P     = out_p_q;

endmodule
